// File: rtl/serv_sleep_ctrl_if.sv
// Handshake bundle between the SERV core and its sleep controller.
// The core side drives the requests and bus-busy flags; the controller drives the gating outputs.
interface serv_sleep_ctrl_if;
    logic i_sleep_req;
    logic i_wakeup_req;
    logic i_ibus_busy;
    logic i_dbus_busy;
    logic o_clk_en;
    logic o_halt;
    logic o_sleeping;
    logic o_wake_done;

    modport master (
        output i_sleep_req, i_wakeup_req, i_ibus_busy, i_dbus_busy,
        input  o_clk_en, o_halt, o_sleeping, o_wake_done
    );

    modport slave (
        input  i_sleep_req, i_wakeup_req, i_ibus_busy, i_dbus_busy,
        output o_clk_en, o_halt, o_sleeping, o_wake_done
    );
endinterface

// File: rtl/serv_sleep_ctrl.sv
// Sleep/wake sequencer for the SERV core: drains outstanding bus traffic, gates the core clock,
// and holds the core halted for WAKE_CYCLES cycles after an interrupt before letting it resume.
//
// state | meaning
// RUN   | core clocked and free-running
// DRAIN | WFI seen, core halted, waiting for ibus/dbus to go idle
// SLEEP | core clock gated off, waiting for an enabled interrupt
// WAKE  | clock restored, core still halted while the wake counter runs down
module serv_sleep_ctrl #(
    parameter int WAKE_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    serv_sleep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] wake_cnt_q, wake_cnt_d;
    logic       wake_done_d;
    logic       clk_en_q;
    logic       halt_q;
    logic       sleeping_q;
    logic       wake_done_q;

    // In SLEEP only the wakeup request is looked at, so junk on the other inputs cannot move state.
    always_comb begin
        state_d     = state_q;
        wake_cnt_d  = wake_cnt_q;
        wake_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.i_sleep_req) begin
                    if (bus.i_wakeup_req) begin
                        wake_done_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.i_wakeup_req) begin
                    state_d     = ST_RUN;
                    wake_done_d = 1'b1;
                end else if (!bus.i_ibus_busy && !bus.i_dbus_busy) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (bus.i_wakeup_req) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q != 8'd0) begin
                    wake_cnt_d = wake_cnt_q - 8'd1;
                end else begin
                    state_d     = ST_RUN;
                    wake_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            wake_cnt_q  <= 8'd0;
            clk_en_q    <= 1'b1;
            halt_q      <= 1'b0;
            sleeping_q  <= 1'b0;
            wake_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wake_cnt_q  <= wake_cnt_d;
            clk_en_q    <= (state_d != ST_SLEEP);
            halt_q      <= (state_d != ST_RUN);
            sleeping_q  <= (state_d == ST_SLEEP);
            wake_done_q <= wake_done_d;
        end
    end

    assign bus.o_clk_en    = clk_en_q;
    assign bus.o_halt      = halt_q;
    assign bus.o_sleeping  = sleeping_q;
    assign bus.o_wake_done = wake_done_q;

endmodule

// File: tb/tb_serv_sleep_ctrl.sv
// Scoreboard bench for serv_sleep_ctrl: two instances (WAKE_CYCLES=4 and 1) share one stimulus
// stream; a phase-level reference model predicts outputs, a monitor pops and compares each cycle.
module tb_serv_sleep_ctrl;

    localparam int W_A = 4;
    localparam int W_B = 1;

    localparam int P_RUN   = 0;
    localparam int P_DRAIN = 1;
    localparam int P_SLEEP = 2;
    localparam int P_WAKE  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serv_sleep_ctrl_if if_a ();
    serv_sleep_ctrl_if if_b ();

    serv_sleep_ctrl #(.WAKE_CYCLES(W_A)) dut_a (.i_clk(clk), .i_rst(rst), .bus(if_a));
    serv_sleep_ctrl #(.WAKE_CYCLES(W_B)) dut_b (.i_clk(clk), .i_rst(rst), .bus(if_b));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // expected {clk_en, halt, sleeping, wake_done} after each clock edge
    logic [3:0] exp_q_a[$];
    logic [3:0] exp_q_b[$];

    int phase_m[2];
    int wake_left_m[2];
    int wake_len_m[2];

    function automatic logic [3:0] model_step(int idx, logic r, logic sl, logic wk,
                                              logic ib, logic db);
        logic done;
        done = 1'b0;
        if (r) begin
            phase_m[idx]     = P_RUN;
            wake_left_m[idx] = 0;
        end else begin
            case (phase_m[idx])
                P_RUN: begin
                    if (sl && wk) done = 1'b1;
                    else if (sl) phase_m[idx] = P_DRAIN;
                end
                P_DRAIN: begin
                    if (wk) begin
                        phase_m[idx] = P_RUN;
                        done = 1'b1;
                    end else if (!ib && !db) begin
                        phase_m[idx] = P_SLEEP;
                    end
                end
                P_SLEEP: begin
                    if (wk) begin
                        phase_m[idx]     = P_WAKE;
                        wake_left_m[idx] = wake_len_m[idx];
                    end
                end
                default: begin
                    wake_left_m[idx] = wake_left_m[idx] - 1;
                    if (wake_left_m[idx] == 0) begin
                        phase_m[idx] = P_RUN;
                        done = 1'b1;
                    end
                end
            endcase
        end
        return {phase_m[idx] != P_SLEEP, phase_m[idx] != P_RUN,
                phase_m[idx] == P_SLEEP, done};
    endfunction

    task automatic cycle_in(input logic r, input logic sl, input logic wk,
                            input logic ib, input logic db);
        @(negedge clk);
        rst = r;
        if_a.i_sleep_req = sl; if_a.i_wakeup_req = wk;
        if_a.i_ibus_busy = ib; if_a.i_dbus_busy  = db;
        if_b.i_sleep_req = sl; if_b.i_wakeup_req = wk;
        if_b.i_ibus_busy = ib; if_b.i_dbus_busy  = db;
        exp_q_a.push_back(model_step(0, r, sl, wk, ib, db));
        exp_q_b.push_back(model_step(1, r, sl, wk, ib, db));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one comparison per instance per clock once a prediction is queued.
    initial begin
        logic [3:0] exp_v;
        logic [3:0] got_v;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q_a.size() > 0) begin
                exp_v = exp_q_a.pop_front();
                got_v = {if_a.o_clk_en, if_a.o_halt, if_a.o_sleeping, if_a.o_wake_done};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL out_w4 cyc=%0d got=%b exp=%b (clk_en,halt,sleeping,wake_done)",
                             cyc, got_v, exp_v);
                end
            end
            if (exp_q_b.size() > 0) begin
                exp_v = exp_q_b.pop_front();
                got_v = {if_b.o_clk_en, if_b.o_halt, if_b.o_sleeping, if_b.o_wake_done};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL out_w1 cyc=%0d got=%b exp=%b (clk_en,halt,sleeping,wake_done)",
                             cyc, got_v, exp_v);
                end
            end
        end
    end

    initial begin
        wake_len_m[0] = W_A;
        wake_len_m[1] = W_B;
        phase_m[0] = P_RUN; phase_m[1] = P_RUN;
        wake_left_m[0] = 0; wake_left_m[1] = 0;
        if_a.i_sleep_req = 1'b0; if_a.i_wakeup_req = 1'b0;
        if_a.i_ibus_busy = 1'b0; if_a.i_dbus_busy  = 1'b0;
        if_b.i_sleep_req = 1'b0; if_b.i_wakeup_req = 1'b0;
        if_b.i_ibus_busy = 1'b0; if_b.i_dbus_busy  = 1'b0;

        // reset state
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // basic sleep/wake cycle
        cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(7);

        // drain held off by dbus for three cycles
        cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(6);

        // sleep and wakeup together in RUN: WFI as NOP
        cycle_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);

        // wakeup during DRAIN with ibus busy
        cycle_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        // stale sleep_req held across the return to RUN re-enters DRAIN
        cycle_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);

        // reset while sleeping, with busy/sleep_req noise ignored in SLEEP
        cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        cycle_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // reset in WAKE with two counts remaining (WAKE_CYCLES=4 instance)
        cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // wakeup pulse dropped mid-WAKE must not abort the wake
        cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(6);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle_in($urandom_range(0, 59) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) == 0);
        end
        idle(8);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 10 && (exp_q_a.size() > 0 || exp_q_b.size() > 0); i++)
            @(posedge clk);
        #2;
        if (exp_q_a.size() > 0 || exp_q_b.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_queue pending_a=%0d pending_b=%0d required=0",
                     exp_q_a.size(), exp_q_b.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
